// File: rtl/nxs_nonce_reporter.sv
// Nonce reporter: captures candidate nonces from parallel hash cores, queues them,
// and streams each one as a 9-byte frame (header + little-endian nonce) to a UART.
module nxs_nonce_reporter #(
  parameter int          HASHERS    = 1,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [7:0]  FRAME_HDR  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          nHashRst,
  input  logic [HASHERS-1:0]            GoodNonceFound,
  input  logic [64*HASHERS-1:0]         NonceOut,
  output logic [7:0]                    TxByte,
  output logic                          TxValid,
  input  logic                          TxReady,
  output logic [$clog2(FIFO_DEPTH):0]   FifoCount,
  output logic                          Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

  logic [HASHERS-1:0]    r_strobe_p0;
  logic [64*HASHERS-1:0] r_nonce_p0;
  logic [HASHERS-1:0]    r_pend_p1;
  logic [63:0]           r_hold_p1 [HASHERS];
  logic                  r_ovf;

  logic [63:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  state_t                r_state;
  logic [63:0]           r_shift;
  logic [2:0]            r_bcnt;
  logic [7:0]            r_tx_byte;
  logic                  r_tx_vld;

  logic [HASHERS-1:0]    w_onehot;
  logic [HASHERS-1:0]    w_drain;
  logic [63:0]           w_wdata;
  logic                  w_any;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_accept;

  assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
  assign w_push   = w_any && ((r_count < CW'(FIFO_DEPTH)) || w_pop);
  assign w_drain  = w_push ? w_onehot : '0;
  assign w_accept = r_tx_vld && TxReady;

  // Fixed-priority pick of the lowest-index pending core
  always_comb begin
    w_onehot = '0;
    w_wdata  = '0;
    w_any    = 1'b0;
    for (int i = 0; i < HASHERS; i++) begin
      if (r_pend_p1[i] && !w_any) begin
        w_onehot[i] = 1'b1;
        w_wdata     = r_hold_p1[i];
        w_any       = 1'b1;
      end
    end
  end

  // ---- p0: input register / p1: per-core holding register ----
  always_ff @(posedge clk) begin
    if (!nHashRst) begin
      r_strobe_p0 <= '0;
      r_pend_p1   <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_strobe_p0 <= GoodNonceFound;
      for (int i = 0; i < HASHERS; i++) begin
        if (r_strobe_p0[i]) begin
          if (!r_pend_p1[i] || w_drain[i]) r_pend_p1[i] <= 1'b1;
          else                             r_ovf        <= 1'b1;
        end else if (w_drain[i]) begin
          r_pend_p1[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    r_nonce_p0 <= NonceOut;
    for (int i = 0; i < HASHERS; i++) begin
      if (r_strobe_p0[i] && (!r_pend_p1[i] || w_drain[i]))
        r_hold_p1[i] <= r_nonce_p0[64*i +: 64];
    end
  end

  // ---- p2: FIFO ----
  always_ff @(posedge clk) begin
    if (!nHashRst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wdata;
  end

  // ---- p3: frame serializer ----
  always_ff @(posedge clk) begin
    if (!nHashRst) begin
      r_state   <= S_IDLE;
      r_bcnt    <= '0;
      r_tx_byte <= '0;
      r_tx_vld  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_byte <= FRAME_HDR;
            r_tx_vld  <= 1'b1;
            r_state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_accept) begin
            r_tx_byte <= r_shift[7:0];
            r_bcnt    <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            if (r_bcnt == 3'd7) begin
              r_tx_vld <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_bcnt    <= r_bcnt + 1'b1;
              r_tx_byte <= r_shift[7:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Shift register always presents the next byte to send in bits [7:0]
  always_ff @(posedge clk) begin
    if (w_pop)                           r_shift <= r_mem[r_rd_ptr];
    else if (w_accept && r_state != S_IDLE) r_shift <= r_shift >> 8;
  end

  assign TxByte    = r_tx_byte;
  assign TxValid   = r_tx_vld;
  assign FifoCount = r_count;
  assign Overflow  = r_ovf;

endmodule
